// File: rtl/cpu_fetch_unit.sv
// cpu_fetch_unit: instruction-fetch front end.
// A two-state sequencer (IDLE/WAIT) issues one memory read at a time and
// pushes {pc, instruction} pairs into a small prefetch FIFO. The FIFO head
// drives the decode stage through a valid/ready handshake. Redirects and
// flushes empty the FIFO; a response already in flight when one of them
// arrives is dropped when it finally returns.

module cpu_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            ctrl,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_ack,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [DATA_W-1:0]      instr_data,
    output logic [ADDR_W-1:0]      instr_pc,
    output logic                   halted,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Next sequential fetch address, wrapping modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] pc_advance(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(PC_STEP);
    endfunction

    // Sequencer state
    state_t              r_state;
    logic                r_mem_req;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic                r_drop;
    logic                r_step_prev;
    logic                r_step_pending;

    // Prefetch FIFO storage
    logic [DATA_W-1:0]   r_fifo_data [DEPTH];
    logic [ADDR_W-1:0]   r_fifo_pc   [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    // Decoded controls and next-state values
    logic                w_run;
    logic                w_step;
    logic                w_flush;
    logic                w_kill;
    logic                w_step_rise;
    logic                w_pop;
    logic                w_has_space;
    logic                w_can_issue;
    logic                w_issue;
    logic                w_xfer;
    logic                w_push;
    state_t              w_state_nxt;
    logic                w_mem_req_nxt;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [ADDR_W-1:0]   w_fetch_pc_nxt;
    logic                w_drop_nxt;
    logic                w_step_pending_nxt;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [PTR_W-1:0]    w_wr_ptr_nxt;
    logic [PTR_W-1:0]    w_rd_ptr_nxt;
    logic                w_unused_ctrl;

    assign w_run         = ctrl[0];
    assign w_step        = ctrl[1];
    assign w_flush       = ctrl[2];
    assign w_unused_ctrl = ^ctrl[15:3];

    // Anything that restarts the stream kills the FIFO contents and any
    // response arriving this cycle.
    assign w_kill      = redirect_valid | w_flush;
    assign w_step_rise = w_step & ~r_step_prev;
    assign w_pop       = instr_valid & instr_ready;
    assign w_has_space = (r_count < CNT_W'(DEPTH));
    assign w_can_issue = (w_run | r_step_pending) & w_has_space & ~w_kill;

    // Sequencer next-state and request outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_mem_req_nxt  = r_mem_req;
        w_mem_addr_nxt = r_mem_addr;
        w_issue        = 1'b0;
        w_xfer         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_can_issue) begin
                    w_issue        = 1'b1;
                    w_state_nxt    = ST_WAIT;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = r_fetch_pc;
                end else begin
                    w_state_nxt    = ST_IDLE;
                    w_mem_req_nxt  = 1'b0;
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    // Transfer edge; the return to IDLE forces one bubble.
                    w_xfer        = 1'b1;
                    w_state_nxt   = ST_IDLE;
                    w_mem_req_nxt = 1'b0;
                end else begin
                    w_state_nxt   = ST_WAIT;
                    w_mem_req_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    // Fetch PC, drop flag and step bookkeeping.
    always_comb begin
        w_push             = w_xfer & ~r_drop & ~w_kill;
        w_fetch_pc_nxt     = r_fetch_pc;
        w_drop_nxt         = r_drop;
        w_step_pending_nxt = r_step_pending;

        if (redirect_valid) begin
            w_fetch_pc_nxt = redirect_pc;
        end else if (w_push) begin
            w_fetch_pc_nxt = pc_advance(r_fetch_pc);
        end else begin
            w_fetch_pc_nxt = r_fetch_pc;
        end

        // A kill while the request is still open poisons its response;
        // a kill on the ack edge itself just discards that word.
        if (w_kill && (r_state == ST_WAIT) && !mem_ack) begin
            w_drop_nxt = 1'b1;
        end else if (w_xfer) begin
            w_drop_nxt = 1'b0;
        end else begin
            w_drop_nxt = r_drop;
        end

        // Issue consumes a pending step; an edge arriving while a step is
        // already pending is not counted.
        if (w_issue) begin
            w_step_pending_nxt = w_step_rise & ~r_step_pending;
        end else begin
            w_step_pending_nxt = r_step_pending | w_step_rise;
        end
    end

    // FIFO occupancy and pointer update; a kill overrides push and pop.
    always_comb begin
        w_count_nxt  = r_count;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_kill) begin
            w_count_nxt  = '0;
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + CNT_W'(1);
                2'b01:   w_count_nxt = r_count - CNT_W'(1);
                default: w_count_nxt = r_count;
            endcase
            if (w_push) begin
                w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
            end else begin
                w_wr_ptr_nxt = r_wr_ptr;
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
            end else begin
                w_rd_ptr_nxt = r_rd_ptr;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered request, fetch PC, drop flag and step tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req      <= 1'b0;
            r_mem_addr     <= RESET_PC;
            r_fetch_pc     <= RESET_PC;
            r_drop         <= 1'b0;
            r_step_prev    <= 1'b0;
            r_step_pending <= 1'b0;
        end else begin
            r_mem_req      <= w_mem_req_nxt;
            r_mem_addr     <= w_mem_addr_nxt;
            r_fetch_pc     <= w_fetch_pc_nxt;
            r_drop         <= w_drop_nxt;
            r_step_prev    <= w_step;
            r_step_pending <= w_step_pending_nxt;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // FIFO storage; cleared on reset so the head reads zero when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= mem_rdata;
                r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
            end else begin
                r_fifo_data[r_wr_ptr] <= r_fifo_data[r_wr_ptr];
                r_fifo_pc[r_wr_ptr]   <= r_fifo_pc[r_wr_ptr];
            end
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr_valid = (r_count != '0);
    assign instr_data  = r_fifo_data[r_rd_ptr];
    assign instr_pc    = r_fifo_pc[r_rd_ptr];
    assign fifo_count  = r_count;
    assign halted      = ~w_run & ~r_mem_req & ~r_step_pending;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed bench for cpu_fetch_unit: reset, streaming, backpressure,
// redirect while waiting, halt/step, and PC wrap on an 8-bit instance.

module tb_cpu_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] ctrl;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        halted;
    logic [2:0]  fifo_count;

    logic [15:0] b_ctrl;
    logic        b_mem_req;
    logic [7:0]  b_mem_addr;
    logic        b_mem_ack;
    logic [31:0] b_mem_rdata;
    logic        b_redirect_valid;
    logic [7:0]  b_redirect_pc;
    logic        b_instr_valid;
    logic        b_instr_ready;
    logic [31:0] b_instr_data;
    logic [7:0]  b_instr_pc;
    logic        b_halted;
    logic [2:0]  b_fifo_count;

    int          total = 0;
    int          bad   = 0;
    int          lat   = 0;
    int          wait_cnt;
    logic        ack_en    = 1'b0;
    logic        force_ack = 1'b0;
    logic [31:0] xfer_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[15:0], ~a[15:0]};
    endfunction

    cpu_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(1)) u_dut (
        .clk(clk), .rst(rst), .ctrl(ctrl),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
        .instr_pc(instr_pc), .halted(halted), .fifo_count(fifo_count)
    );

    cpu_fetch_unit #(.ADDR_W(8), .DATA_W(32), .DEPTH(4), .RESET_PC(8'hFE), .PC_STEP(1)) u_dut_wrap (
        .clk(clk), .rst(rst), .ctrl(b_ctrl),
        .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata),
        .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
        .instr_valid(b_instr_valid), .instr_ready(b_instr_ready), .instr_data(b_instr_data),
        .instr_pc(b_instr_pc), .halted(b_halted), .fifo_count(b_fifo_count)
    );

    // Memory model: ack after `lat` waiting cycles, data is a fixed function of address.
    assign mem_ack     = force_ack | (ack_en & mem_req & (wait_cnt >= lat));
    assign mem_rdata   = mem_word(mem_addr);
    assign b_mem_ack   = b_mem_req;
    assign b_mem_rdata = mem_word({24'h0, b_mem_addr});

    // Count cycles the current request has been waiting.
    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 0;
        else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    // Log the address of every completed transfer.
    always @(posedge clk) begin
        if (!rst && mem_req && mem_ack) xfer_q.push_back(mem_addr);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] xfer_at(input int i);
        if (i < xfer_q.size()) return xfer_q[i];
        else return 32'hDEAD_BEEF;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!instr_valid && n < budget) begin
            tick();
            n++;
        end
        check(tag, {63'h0, instr_valid}, 64'h1);
    endtask

    logic [7:0] exp_wrap [4];

    initial begin
        rst = 1'b1; ctrl = 16'h0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        instr_ready = 1'b0;
        b_ctrl = 16'h0; b_redirect_valid = 1'b0; b_redirect_pc = 8'h0; b_instr_ready = 1'b1;
        exp_wrap[0] = 8'hFE; exp_wrap[1] = 8'hFF; exp_wrap[2] = 8'h00; exp_wrap[3] = 8'h01;

        tick();
        tick();
        check("init_req",    {63'h0, mem_req}, 64'h0);
        check("init_halted", {63'h0, halted}, 64'h1);
        check("init_wrap_count", {61'h0, b_fifo_count}, 64'h0);
        check("init_wrap_halted", {63'h0, b_halted}, 64'h1);
        rst = 1'b0;

        // Reset in the middle of a request at address 5.
        redirect_valid = 1'b1; redirect_pc = 32'h5;
        tick();
        redirect_valid = 1'b0; ctrl = 16'h1;
        tick();
        check("pre_rst_req",  {63'h0, mem_req}, 64'h1);
        check("pre_rst_addr", {32'h0, mem_addr}, 64'h5);
        tick();
        rst = 1'b1; ctrl = 16'h0;
        #1;
        check("rst_req",    {63'h0, mem_req}, 64'h0);
        check("rst_addr",   {32'h0, mem_addr}, 64'h0);
        check("rst_valid",  {63'h0, instr_valid}, 64'h0);
        check("rst_count",  {61'h0, fifo_count}, 64'h0);
        check("rst_halted", {63'h0, halted}, 64'h1);
        check("rst_data",   {32'h0, instr_data}, 64'h0);
        check("rst_pc",     {32'h0, instr_pc}, 64'h0);
        tick();
        rst = 1'b0; force_ack = 1'b1;
        tick();
        tick();
        force_ack = 1'b0;
        check("late_ack_count", {61'h0, fifo_count}, 64'h0);
        check("late_ack_valid", {63'h0, instr_valid}, 64'h0);
        check("late_ack_req",   {63'h0, mem_req}, 64'h0);

        // Zero-wait streaming.
        lat = 0; ack_en = 1'b1; instr_ready = 1'b1; ctrl = 16'h1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("stream_req_hi", {63'h0, mem_req}, 64'h1);
            check("stream_addr",   {32'h0, mem_addr}, 64'(k));
            tick();
            check("stream_req_lo", {63'h0, mem_req}, 64'h0);
            check("stream_valid",  {63'h0, instr_valid}, 64'h1);
            check("stream_pc",     {32'h0, instr_pc}, 64'(k));
            check("stream_data",   {32'h0, instr_data}, {32'h0, mem_word(k)});
        end
        ctrl = 16'h0;
        tick();
        check("stream_end_count",  {61'h0, fifo_count}, 64'h0);
        check("stream_end_halted", {63'h0, halted}, 64'h1);

        // Backpressure: FIFO fills to DEPTH, then one pop allows one fetch.
        do_reset();
        xfer_q.delete();
        instr_ready = 1'b0; lat = 0; ctrl = 16'h1;
        repeat (20) tick();
        check("bp_xfers", 64'(xfer_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) check("bp_xfer_addr", {32'h0, xfer_at(i)}, 64'(i));
        check("bp_count", {61'h0, fifo_count}, 64'h4);
        check("bp_req",   {63'h0, mem_req}, 64'h0);
        check("bp_head_pc",   {32'h0, instr_pc}, 64'h0);
        check("bp_head_data", {32'h0, instr_data}, {32'h0, mem_word(32'h0)});
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("bp_pop_count", {61'h0, fifo_count}, 64'h3);
        check("bp_pop_pc",    {32'h0, instr_pc}, 64'h1);
        repeat (10) tick();
        check("bp_refill_xfers", 64'(xfer_q.size()), 64'd5);
        check("bp_refill_addr",  {32'h0, xfer_at(4)}, 64'h4);
        check("bp_refill_count", {61'h0, fifo_count}, 64'h4);
        check("bp_refill_req",   {63'h0, mem_req}, 64'h0);

        // Redirect while a slow request is outstanding.
        ctrl = 16'h0;
        do_reset();
        xfer_q.delete();
        instr_ready = 1'b0; lat = 0; ctrl = 16'h1;
        repeat (4) tick();
        check("rd_prefill_count", {61'h0, fifo_count}, 64'h2);
        lat = 3;
        tick();
        check("rd_req",  {63'h0, mem_req}, 64'h1);
        check("rd_addr", {32'h0, mem_addr}, 64'h2);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check("rd_flush_count", {61'h0, fifo_count}, 64'h0);
        check("rd_flush_valid", {63'h0, instr_valid}, 64'h0);
        check("rd_hold_req",    {63'h0, mem_req}, 64'h1);
        check("rd_hold_addr",   {32'h0, mem_addr}, 64'h2);
        instr_ready = 1'b1;
        wait_valid("rd_wait_timeout", 30);
        check("rd_new_pc",     {32'h0, instr_pc}, 64'h100);
        check("rd_new_data",   {32'h0, instr_data}, {32'h0, mem_word(32'h100)});
        check("rd_xfers",      64'(xfer_q.size()), 64'd4);
        check("rd_drop_addr",  {32'h0, xfer_at(2)}, 64'h2);
        check("rd_next_addr",  {32'h0, xfer_at(3)}, 64'h100);

        // Halt and single step; reserved control bits must not start fetch.
        ctrl = 16'h0; lat = 0;
        do_reset();
        xfer_q.delete();
        instr_ready = 1'b1; ctrl = 16'hFFF8;
        repeat (5) tick();
        check("halt_xfers",  64'(xfer_q.size()), 64'd0);
        check("halt_halted", {63'h0, halted}, 64'h1);
        check("halt_req",    {63'h0, mem_req}, 64'h0);
        ctrl = 16'h2;
        tick();
        ctrl = 16'h0;
        check("step_pending_halted", {63'h0, halted}, 64'h0);
        repeat (6) tick();
        ctrl = 16'h2;
        tick();
        ctrl = 16'h0;
        repeat (6) tick();
        check("step2_xfers",  64'(xfer_q.size()), 64'd2);
        check("step2_addr0",  {32'h0, xfer_at(0)}, 64'h0);
        check("step2_addr1",  {32'h0, xfer_at(1)}, 64'h1);
        check("step2_halted", {63'h0, halted}, 64'h1);
        ctrl = 16'h2;
        repeat (10) tick();
        ctrl = 16'h0;
        repeat (4) tick();
        check("step_hold_xfers", 64'(xfer_q.size()), 64'd3);
        check("step_hold_addr",  {32'h0, xfer_at(2)}, 64'h2);
        check("step_hold_halted", {63'h0, halted}, 64'h1);

        // PC wrap on the 8-bit instance starting at 0xFE.
        b_ctrl = 16'h1;
        for (int k = 0; k < 4; k++) begin
            int n;
            n = 0;
            while (!b_instr_valid && n < 20) begin
                tick();
                n++;
            end
            check("wrap_valid", {63'h0, b_instr_valid}, 64'h1);
            check("wrap_pc",    {56'h0, b_instr_pc}, {56'h0, exp_wrap[k]});
            check("wrap_data",  {32'h0, b_instr_data}, {32'h0, mem_word({24'h0, exp_wrap[k]})});
            tick();
        end
        b_ctrl = 16'h0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_fetch_unit.md
Name: cpu_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation CPU.
- Replaces the free-running address increment with the following:
  - a run/step/flush-controlled fetch sequencer;
  - a request/acknowledge memory handshake;
  - a DEPTH-entry prefetch FIFO that delivers {pc, instruction} pairs to the decode stage over a valid/ready interface.
- Sits between the memory bus and the CPU execute state machine; the execute state machine drives redirects (branches and jumps).

Parameters:
ADDR_W, 32, width of the program counter and memory address.
DATA_W, 32, instruction/memory data width.
DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
RESET_PC, 0, fetch address after reset.
PC_STEP, 1, increment added to the PC per fetched word.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous reset, active high.
ctrl  input  16  control bits: [0] run (level), [1] step (rising edge), [2] flush (level, one-cycle pulse expected); [15:3] reserved and ignored.
mem_req  output  1  memory read request (registered).
mem_addr  output  ADDR_W  read address; stable while mem_req is high.
mem_ack  input  1  memory acknowledge; a transfer occurs on an edge where mem_req && mem_ack.
mem_rdata  input  DATA_W  read data; valid with mem_ack.
redirect_valid  input  1  one-cycle pulse; restarts fetch at redirect_pc.
redirect_pc  input  ADDR_W  new fetch address.
instr_valid  output  1  FIFO head valid.
instr_ready  input  1  consumer accepts the head; a pop occurs when instr_valid && instr_ready.
instr_data  output  DATA_W  head instruction.
instr_pc  output  ADDR_W  address the head instruction was fetched from.
halted  output  1  high when ctrl[0]=0, no request is outstanding and no step is pending.
fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, any cycle): all of the following take effect immediately.
  - fetch_pc=RESET_PC; mem_req=0; mem_addr=RESET_PC.
  - FIFO empty: instr_valid=0, fifo_count=0, instr_data=0, instr_pc=0.
  - drop flag=0; step edge-detector history=0; step_pending=0; halted=1.
  - An in-flight request is abandoned; a mem_ack after reset with mem_req=0 is ignored.
- State machine, IDLE / WAIT:
  - IDLE, mem_req=0: a request is issued at an edge if all of these hold:
    - (ctrl[0] or step_pending);
    - fifo_count < DEPTH (count before any same-edge pop);
    - no redirect_valid or ctrl[2] this cycle.
  - On issue: mem_req<=1, mem_addr<=fetch_pc, go to WAIT, clear step_pending.
  - WAIT: mem_req and mem_addr are held until the transfer edge.
  - On the transfer edge:
    - mem_req<=0 and go to IDLE, giving one mandatory bubble cycle;
    - if the drop flag is clear: push {fetch_pc, mem_rdata} and set fetch_pc<=fetch_pc+PC_STEP (mod 2^ADDR_W);
    - if the drop flag is set: discard the data and clear the flag.
  - Peak throughput is therefore one word per 2 cycles with a zero-wait memory; at most one request is outstanding.
- Step:
  - A ctrl[1] rising edge sets step_pending. It permits exactly one issue even with run=0.
  - Further edges while pending are not counted.
- Redirect and flush (ctrl[2]):
  - FIFO flushed: count 0 at the next edge; flush wins over a same-cycle pop and a same-cycle push.
  - On redirect, fetch_pc<=redirect_pc; flush alone keeps fetch_pc.
  - If in WAIT without ack this cycle: set the drop flag, keep mem_req/mem_addr stable, and discard the eventual response.
  - If the ack coincides with the redirect: the data is discarded and the drop flag is not set.
- FIFO:
  - Simultaneous push and pop: count unchanged.
  - Pop on empty is impossible (instr_valid=0).
  - A push when count==DEPTH cannot occur by the issue rule.
  - Outputs come straight from the head registers, so pushed data is visible the cycle after the transfer edge.
- Halting: run=0 mid-WAIT lets the outstanding request complete and push; no further issue. The FIFO continues draining.
- Reserved ctrl bits have no effect.

Test Plan:
- Reset values: assert rst mid-WAIT with mem_addr=5 -> immediately mem_req=0, mem_addr=RESET_PC, instr_valid=0, fifo_count=0, halted=1; a late mem_ack pushes nothing.
- Zero-wait stream: mem_ack=mem_req, instr_ready=1, ctrl=1 after reset -> mem_req high every other cycle; instr_pc sequence 0,1,2,3,...; instr_data equals memory[pc].
- Backpressure: instr_ready=0, DEPTH=4 -> exactly 4 transfers (pc 0..3), then fifo_count=4 and mem_req stays 0; one pop -> exactly one further request at addr 4.
- Redirect in WAIT: memory acks 3 cycles late; redirect_pc=0x100 while pending -> the pending data is dropped; FIFO empty next cycle; the next request's mem_addr=0x100 and its instr_pc=0x100.
- Halt/step: ctrl[0]=0 -> no requests, halted=1; pulse ctrl[1] twice with a gap -> exactly two fetches at consecutive PCs; holding ctrl[1] high yields one fetch only.
- Wrap: ADDR_W=8, RESET_PC=8'hFE -> fetched PCs FE, FF, 00, 01.
